// File: rtl/dmi_jtag_access.sv
// -----------------------------------------------------------------------------
// dmi_jtag_access
//
// JTAG-side DMI access engine. It sits between the TAP "dmi" data register and
// the JTAG-clock port of the DMI clock-domain crossing. A TAP update-DR becomes
// a dmi request (valid/ready), and the response comes back through ready/valid.
// The engine also keeps the sticky op-status that the TAP captures
// (0 ok, 2 failed, 3 busy) and handles the dtmcs dmireset / dmihardreset
// pulses.
//
// Optional feature (compile-time macro): DMI_ACCESS_TIMEOUT_EN
//   Defined   : a cycle counter runs while waiting for a response. After
//               TIMEOUT_CYC cycles without one, the access is marked failed and
//               the engine drains (discards) the late response.
//   Undefined : no counter; the engine waits for a response indefinitely.
//
// Parameters
//   ABITS        dmi address width
//   TIMEOUT_CYC  response timeout in cycles (only used with the macro defined)
//
// Ports
//   clk_i             TCK, the only clock
//   rst_i             synchronous active-high reset
//   update_dr_i       1-cycle pulse; dr_i holds the shifted dmi register
//   capture_dr_i      1-cycle pulse; the TAP samples capture_o next cycle
//   dr_i              {addr[ABITS], data[32], op[2]}
//   capture_o         {addr_q, data_q, status_q}, registered on capture_dr_i
//   dmi_reset_i       dtmcs.dmireset pulse: clears the sticky status
//   dmi_hard_reset_i  dtmcs.dmihardreset pulse: aborts the current access
//   dmi_req_*_o       request address / write data / op (1 read, 2 write) / valid
//   dmi_req_ready_i   CDC accepts the request
//   dmi_resp_*_i      response read data / code (0 ok) / valid
//   dmi_resp_ready_o  engine accepts a response
// -----------------------------------------------------------------------------
module dmi_jtag_access #(
   parameter int ABITS       = 7,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              update_dr_i,
   input  logic              capture_dr_i,
   input  logic [ABITS+33:0] dr_i,
   output logic [ABITS+33:0] capture_o,
   input  logic              dmi_reset_i,
   input  logic              dmi_hard_reset_i,
   output logic [ABITS-1:0]  dmi_req_addr_o,
   output logic [31:0]       dmi_req_data_o,
   output logic [1:0]        dmi_req_op_o,
   output logic              dmi_req_valid_o,
   input  logic              dmi_req_ready_i,
   input  logic [31:0]       dmi_resp_data_i,
   input  logic [1:0]        dmi_resp_resp_i,
   input  logic              dmi_resp_valid_i,
   output logic              dmi_resp_ready_o
);

   localparam logic [1:0] OP_READ    = 2'd1;
   localparam logic [1:0] OP_WRITE   = 2'd2;
   localparam logic [1:0] STS_OK     = 2'd0;
   localparam logic [1:0] STS_FAILED = 2'd2;
   localparam logic [1:0] STS_BUSY   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DRAIN
   } state_e;

   state_e             state_q, state_d;
   logic [ABITS-1:0]   addr_q, addr_d;
   logic [31:0]        data_q, data_d;
   logic [1:0]         op_q, op_d;
   logic [1:0]         status_q, status_d;
   logic [ABITS+33:0]  capture_q, capture_d;
   logic               timeout;

   logic [ABITS-1:0]   drAddr;
   logic [31:0]        drData;
   logic [1:0]         drOp;

   assign drAddr = dr_i[ABITS+33:34];
   assign drData = dr_i[33:2];
   assign drOp   = dr_i[1:0];

`ifdef DMI_ACCESS_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Count cycles spent in WAIT; the count restarts whenever WAIT is left.
   // The timeout fires on the TIMEOUT_CYC-th WAIT cycle if no response shows up
   // in that same cycle, so the counter never needs to go past TIMEOUT_CYC-1.
   always_comb begin
      cnt_d = '0;
      if (state_q == ST_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign timeout = (state_q == ST_WAIT) && (cnt_q == CW'(TIMEOUT_CYC - 1));
`else
   assign timeout = 1'b0;
`endif

   // Next-state and output decode. Status updates are layered in a fixed
   // order: the dmireset/dmihardreset clears go first, so a same-cycle update
   // or busy check sees status 0. The busy check comes next, so a capture
   // during an access already reports 3. Response/timeout failures only write
   // 2 onto a clean status, which keeps 2 and 3 from overwriting each other.
   always_comb begin
      state_d          = state_q;
      addr_d           = addr_q;
      data_d           = data_q;
      op_d             = op_q;
      status_d         = status_q;
      capture_d        = capture_q;
      dmi_req_valid_o  = 1'b0;
      dmi_resp_ready_o = 1'b0;

      if (dmi_reset_i || dmi_hard_reset_i) begin
         status_d = STS_OK;
      end

      if ((state_q != ST_IDLE) && (update_dr_i || capture_dr_i) && (status_d == STS_OK)) begin
         status_d = STS_BUSY;
      end

      case (state_q)
         ST_IDLE: begin
            if (update_dr_i && (status_d == STS_OK) && ((drOp == OP_READ) || (drOp == OP_WRITE))) begin
               addr_d  = drAddr;
               data_d  = drData;
               op_d    = drOp;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            dmi_req_valid_o = 1'b1;
            if (dmi_req_ready_i) begin
               state_d = dmi_hard_reset_i ? ST_DRAIN : ST_WAIT;
            end else if (dmi_hard_reset_i) begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            dmi_resp_ready_o = 1'b1;
            if (dmi_resp_valid_i) begin
               state_d = ST_IDLE;
               if (!dmi_hard_reset_i) begin
                  if (op_q == OP_READ) begin
                     data_d = dmi_resp_data_i;
                  end
                  if ((dmi_resp_resp_i != 2'd0) && (status_d == STS_OK)) begin
                     status_d = STS_FAILED;
                  end
               end
            end else if (dmi_hard_reset_i) begin
               state_d = ST_DRAIN;
            end else if (timeout) begin
               if (status_d == STS_OK) begin
                  status_d = STS_FAILED;
               end
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            dmi_resp_ready_o = 1'b1;
            if (dmi_resp_valid_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (capture_dr_i) begin
         capture_d = {addr_q, data_q, status_d};
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         data_q    <= '0;
         op_q      <= '0;
         status_q  <= STS_OK;
         capture_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         op_q      <= op_d;
         status_q  <= status_d;
         capture_q <= capture_d;
      end
   end

   assign capture_o      = capture_q;
   assign dmi_req_addr_o = addr_q;
   assign dmi_req_data_o = data_q;
   assign dmi_req_op_o   = op_q;

endmodule

// File: tb/tb_dmi_jtag_access.sv
// -----------------------------------------------------------------------------
// tb_dmi_jtag_access
//
// Self-checking bench for dmi_jtag_access. A directed table of transactions
// runs first, then hand-written sequences for busy, hard-reset, timeout and
// reset corner cases, then randomized transactions. A transaction-level
// reference model predicts the random results. The bench plays both the TAP
// and the DMI CDC side.
// -----------------------------------------------------------------------------
module tb_dmi_jtag_access;

   localparam int ABITS = 7;
   localparam int TO    = 16;

   typedef struct {
      logic [1:0]  op;
      logic [6:0]  addr;
      logic [31:0] data;
      int          delay;
      logic [1:0]  respCode;
      logic [31:0] respData;
      bit          clearFirst;
      bit          busyPoke;
      bit          expReq;
      logic [40:0] expCap;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        updateDr, captureDr;
   logic [40:0] dr;
   logic [40:0] captureO;
   logic        dmiReset, hardReset;
   logic [6:0]  reqAddr;
   logic [31:0] reqData;
   logic [1:0]  reqOp;
   logic        reqValid, reqReady;
   logic [31:0] respData;
   logic [1:0]  respResp;
   logic        respValid, respReady;

   int nAsserts = 0;
   int nFails   = 0;

   dmi_jtag_access #(.ABITS(ABITS), .TIMEOUT_CYC(TO)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .update_dr_i      (updateDr),
      .capture_dr_i     (captureDr),
      .dr_i             (dr),
      .capture_o        (captureO),
      .dmi_reset_i      (dmiReset),
      .dmi_hard_reset_i (hardReset),
      .dmi_req_addr_o   (reqAddr),
      .dmi_req_data_o   (reqData),
      .dmi_req_op_o     (reqOp),
      .dmi_req_valid_o  (reqValid),
      .dmi_req_ready_i  (reqReady),
      .dmi_resp_data_i  (respData),
      .dmi_resp_resp_i  (respResp),
      .dmi_resp_valid_i (respValid),
      .dmi_resp_ready_o (respReady)
   );

   // 100 MHz-style free-running clock.
   always #5 clk = ~clk;

   // The TAP never issues update-DR and capture-DR together.
   always @(posedge clk) begin
      assert (!(updateDr && captureDr)) else $error("[TB] update and capture pulses coincide");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nAsserts++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic doUpdate(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
      dr       = {addr, data, op};
      updateDr = 1'b1;
      tick();
      updateDr = 1'b0;
   endtask

   task automatic pulseCapture();
      captureDr = 1'b1;
      tick();
      captureDr = 1'b0;
   endtask

   task automatic handshake();
      reqReady = 1'b1;
      tick();
      reqReady = 1'b0;
   endtask

   task automatic respond(input logic [31:0] d, input logic [1:0] code);
      respValid = 1'b1;
      respData  = d;
      respResp  = code;
      tick();
      respValid = 1'b0;
   endtask

   // One whole transaction: update, optional stalled request, response, capture.
   task automatic applyStimulus(input vec_t v, input string tag);
      dr       = {v.addr, v.data, v.op};
      updateDr = 1'b1;
      dmiReset = v.clearFirst;
      tick();
      updateDr = 1'b0;
      dmiReset = 1'b0;
      checkOutput({tag, ".valid"}, 64'(reqValid), 64'(v.expReq));
      if (v.expReq) begin
         checkOutput({tag, ".addr"}, 64'(reqAddr), 64'(v.addr));
         checkOutput({tag, ".data"}, 64'(reqData), 64'(v.data));
         checkOutput({tag, ".op"}, 64'(reqOp), 64'(v.op));
         if (v.delay > 0) begin
            repeat (v.delay) tick();
            checkOutput({tag, ".stallValid"}, 64'(reqValid), 64'd1);
            checkOutput({tag, ".stallFields"}, {23'd0, reqAddr, reqData, reqOp},
                        {23'd0, v.addr, v.data, v.op});
         end
         handshake();
         checkOutput({tag, ".waitValid"}, 64'(reqValid), 64'd0);
         checkOutput({tag, ".waitRespReady"}, 64'(respReady), 64'd1);
         if (v.busyPoke) begin
            doUpdate(2'd1, 7'h7E, 32'hFFFF_FFFF);
            checkOutput({tag, ".pokeNoReq"}, 64'(reqValid), 64'd0);
         end
         respond(v.respData, v.respCode);
         checkOutput({tag, ".idleRespReady"}, 64'(respReady), 64'd0);
      end
      pulseCapture();
      checkOutput({tag, ".capture"}, 64'(captureO), 64'(v.expCap));
   endtask

   function automatic vec_t mkVec(logic [1:0] op, logic [6:0] addr, logic [31:0] data, int delay,
                                  logic [1:0] rc, logic [31:0] rd, bit clr, bit poke,
                                  bit expReq, logic [40:0] expCap);
      vec_t v;
      v.op = op; v.addr = addr; v.data = data; v.delay = delay;
      v.respCode = rc; v.respData = rd; v.clearFirst = clr; v.busyPoke = poke;
      v.expReq = expReq; v.expCap = expCap;
      return v;
   endfunction

   vec_t vecs[9];

   // Transaction-level reference model state for the random phase.
   logic [6:0]  mAddr;
   logic [31:0] mData;
   logic [1:0]  mStatus;

   initial begin
      vec_t rv;

      rst = 1'b1; updateDr = 0; captureDr = 0; dr = '0; dmiReset = 0; hardReset = 0;
      reqReady = 0; respData = '0; respResp = '0; respValid = 0;

      //                op     addr   data           dly rc     respData      clr poke req expCap
      vecs[0] = mkVec(2'd1, 7'h11, 32'h0,          0, 2'd0, 32'hDEADBEEF, 0, 0, 1, {7'h11, 32'hDEADBEEF, 2'd0});
      vecs[1] = mkVec(2'd2, 7'h04, 32'h1234_5678,  5, 2'd2, 32'h0,        0, 0, 1, {7'h04, 32'h1234_5678, 2'd2});
      vecs[2] = mkVec(2'd2, 7'h05, 32'h0000_AAAA,  0, 2'd0, 32'h0,        0, 0, 0, {7'h04, 32'h1234_5678, 2'd2});
      vecs[3] = mkVec(2'd0, 7'h7F, 32'hFFFF_FFFF,  0, 2'd0, 32'h0,        1, 0, 0, {7'h04, 32'h1234_5678, 2'd0});
      vecs[4] = mkVec(2'd1, 7'h22, 32'h0,          2, 2'd0, 32'hCAFE_F00D, 0, 0, 1, {7'h22, 32'hCAFE_F00D, 2'd0});
      vecs[5] = mkVec(2'd2, 7'h33, 32'h0BAD_F00D,  1, 2'd0, 32'h5555_5555, 0, 0, 1, {7'h33, 32'h0BAD_F00D, 2'd0});
      vecs[6] = mkVec(2'd3, 7'h01, 32'h1,          0, 2'd0, 32'h0,        0, 0, 0, {7'h33, 32'h0BAD_F00D, 2'd0});
      vecs[7] = mkVec(2'd1, 7'h44, 32'h0,          0, 2'd1, 32'h1111_2222, 0, 0, 1, {7'h44, 32'h1111_2222, 2'd2});
      vecs[8] = mkVec(2'd1, 7'h55, 32'h0,          0, 2'd0, 32'h0102_0304, 1, 0, 1, {7'h55, 32'h0102_0304, 2'd0});

      tick(); tick();
      rst = 1'b0;
      checkOutput("rst.valid", 64'(reqValid), 64'd0);
      checkOutput("rst.respReady", 64'(respReady), 64'd0);
      checkOutput("rst.capture", 64'(captureO), 64'd0);
      checkOutput("rst.reqFields", {23'd0, reqAddr, reqData, reqOp}, 64'd0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Busy: capture during REQ and update during WAIT both flag 3.
      doUpdate(2'd1, 7'h10, 32'h0);
      checkOutput("busy.valid", 64'(reqValid), 64'd1);
      pulseCapture();
      checkOutput("busy.capInReq", 64'(captureO), 64'({7'h10, 32'h0, 2'd3}));
      checkOutput("busy.stillValid", 64'(reqValid), 64'd1);
      handshake();
      doUpdate(2'd2, 7'h11, 32'h1);
      checkOutput("busy.noSecondReq", 64'(reqValid), 64'd0);
      respond(32'hA5A5_A5A5, 2'd0);
      doUpdate(2'd1, 7'h12, 32'h0);
      checkOutput("busy.stickyIgnored", 64'(reqValid), 64'd0);
      pulseCapture();
      checkOutput("busy.capAfter", 64'(captureO), 64'({7'h10, 32'hA5A5_A5A5, 2'd3}));
      dmiReset = 1'b1; tick(); dmiReset = 1'b0;
      pulseCapture();
      checkOutput("busy.cleared", 64'(captureO), 64'({7'h10, 32'hA5A5_A5A5, 2'd0}));
      doUpdate(2'd1, 7'h13, 32'h0);
      checkOutput("busy.nextValid", 64'(reqValid), 64'd1);
      checkOutput("busy.nextAddr", 64'(reqAddr), 64'h13);
      handshake();
      respond(32'h1313_1313, 2'd0);

      // Hard reset while waiting: late response drained, data untouched.
      doUpdate(2'd1, 7'h20, 32'h77);
      handshake();
      hardReset = 1'b1; tick(); hardReset = 1'b0;
      checkOutput("hrWait.respReady", 64'(respReady), 64'd1);
      checkOutput("hrWait.valid", 64'(reqValid), 64'd0);
      respond(32'hFFFF_0000, 2'd1);
      checkOutput("hrWait.idle", 64'(respReady), 64'd0);
      pulseCapture();
      checkOutput("hrWait.capture", 64'(captureO), 64'({7'h20, 32'h77, 2'd0}));

      // Response and hard reset in the same cycle: consumed and discarded.
      doUpdate(2'd1, 7'h21, 32'h88);
      handshake();
      hardReset = 1'b1;
      respond(32'h1212_1212, 2'd2);
      hardReset = 1'b0;
      checkOutput("hrSame.idle", 64'(respReady), 64'd0);
      pulseCapture();
      checkOutput("hrSame.capture", 64'(captureO), 64'({7'h21, 32'h88, 2'd0}));

      // Hard reset in REQ with no handshake: valid drops, back to IDLE.
      doUpdate(2'd2, 7'h30, 32'h99);
      hardReset = 1'b1; tick(); hardReset = 1'b0;
      checkOutput("hrReq.valid", 64'(reqValid), 64'd0);
      checkOutput("hrReq.respReady", 64'(respReady), 64'd0);
      pulseCapture();
      checkOutput("hrReq.capture", 64'(captureO), 64'({7'h30, 32'h99, 2'd0}));

`ifdef DMI_ACCESS_TIMEOUT_EN
      // Response in the last allowed WAIT cycle is still accepted.
      doUpdate(2'd1, 7'h50, 32'h5050);
      handshake();
      repeat (TO - 1) tick();
      respond(32'h600D_600D, 2'd0);
      pulseCapture();
      checkOutput("to.justInTime", 64'(captureO), 64'({7'h50, 32'h600D_600D, 2'd0}));
      // One cycle later the access times out and the late response is dropped.
      doUpdate(2'd1, 7'h51, 32'h5151);
      handshake();
      repeat (TO) tick();
      checkOutput("to.drainReady", 64'(respReady), 64'd1);
      respond(32'hBAD0_BAD0, 2'd0);
      checkOutput("to.idle", 64'(respReady), 64'd0);
      pulseCapture();
      checkOutput("to.capture", 64'(captureO), 64'({7'h51, 32'h5151, 2'd2}));
`else
      // Without the timeout the engine keeps waiting.
      doUpdate(2'd1, 7'h52, 32'h5252);
      handshake();
      repeat (40) tick();
      checkOutput("noTo.stillWaiting", 64'(respReady), 64'd1);
      respond(32'h0F0F_0F0F, 2'd0);
      pulseCapture();
      checkOutput("noTo.capture", 64'(captureO), 64'({7'h52, 32'h0F0F_0F0F, 2'd0}));
`endif

      // Synchronous reset in the middle of a request.
      doUpdate(2'd1, 7'h40, 32'h4);
      checkOutput("rstReq.valid", 64'(reqValid), 64'd1);
      rst = 1'b1; tick();
      checkOutput("rstReq.validLow", 64'(reqValid), 64'd0);
      checkOutput("rstReq.capture", 64'(captureO), 64'd0);
      rst = 1'b0;

      // Randomized transactions against the transaction-level model.
      mAddr = '0; mData = '0; mStatus = 2'd0;
      for (int i = 0; i < 40; i++) begin
         rv.op         = 2'($urandom_range(0, 3));
         rv.addr       = 7'($urandom);
         rv.data       = $urandom;
         rv.delay      = int'($urandom_range(0, 3));
         rv.respCode   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
         rv.respData   = $urandom;
         rv.clearFirst = ($urandom_range(0, 2) == 0);
         rv.busyPoke   = ($urandom_range(0, 5) == 0);
         if (rv.clearFirst) mStatus = 2'd0;
         rv.expReq = (mStatus == 2'd0) && (rv.op == 2'd1 || rv.op == 2'd2);
         if (rv.expReq) begin
            mAddr = rv.addr;
            mData = (rv.op == 2'd1) ? rv.respData : rv.data;
            if (rv.busyPoke) mStatus = 2'd3;
            else if (rv.respCode != 2'd0) mStatus = 2'd2;
         end
         rv.expCap = {mAddr, mData, mStatus};
         applyStimulus(rv, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
